// File: rtl/mission_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mission_pkg
//  Purpose  : Shared constants, state encoding and helpers for the mission
//             scheduler (unit codes, turn direction codes, path limits).
//  Revision : 1.0 - initial release
// ============================================================================
package mission_pkg;

    // Unit codes carried by each queued task
    localparam logic [1:0] UNIT_PU   = 2'd0;
    localparam logic [1:0] UNIT_FU   = 2'd1;
    localparam logic [1:0] UNIT_WU   = 2'd2;
    localparam logic [1:0] UNIT_RSVD = 2'd3;

    // Two-bit turn codes packed into node_directions
    localparam logic [1:0] DIR_LEFT     = 2'b01;
    localparam logic [1:0] DIR_RIGHT    = 2'b10;
    localparam logic [1:0] DIR_STRAIGHT = 2'b11;

    // Longest path the navigation logic can hold
    localparam logic [3:0] MAX_PATH_NODES = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ_PATH = 3'd1,
        ST_RUN_PATH = 3'd2,
        ST_RUN_UNIT = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    // One-hot Go_to vector {WU, FU, PU} for a unit code
    function automatic logic [2:0] unit_onehot(input logic [1:0] unit);
        logic [2:0] v;
        v = 3'b000;
        case (unit)
            UNIT_PU: v = 3'b001;
            UNIT_FU: v = 3'b010;
            UNIT_WU: v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mission_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : mission_scheduler_if
//  Purpose  : Task handshake, path-planner, navigation and status signals of
//             the mission scheduler. master = scheduler, slave = environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface mission_scheduler_if;

    logic        task_valid;
    logic        task_ready;
    logic [1:0]  task_unit;

    logic        plan_req;
    logic [4:0]  plan_target;
    logic        plan_ack;
    logic [23:0] plan_dirs;
    logic [3:0]  plan_len;
    logic [4:0]  plan_prev;

    logic [23:0] node_directions;
    logic [3:0]  path_length;
    logic [4:0]  prev_node_of_end_point;
    logic        nav_reset;
    logic        Go_to_PU;
    logic        Go_to_FU;
    logic        Go_to_WU;
    logic        arrived;
    logic        unit_lap_done;

    logic        clear_fault;
    logic        busy;
    logic        task_done;
    logic [7:0]  tasks_completed;
    logic        fault;

    modport master (
        input  task_valid, task_unit,
        output task_ready,
        output plan_req, plan_target,
        input  plan_ack, plan_dirs, plan_len, plan_prev,
        output node_directions, path_length, prev_node_of_end_point, nav_reset,
        output Go_to_PU, Go_to_FU, Go_to_WU,
        input  arrived, unit_lap_done, clear_fault,
        output busy, task_done, tasks_completed, fault
    );

    modport slave (
        output task_valid, task_unit,
        input  task_ready,
        input  plan_req, plan_target,
        output plan_ack, plan_dirs, plan_len, plan_prev,
        input  node_directions, path_length, prev_node_of_end_point, nav_reset,
        input  Go_to_PU, Go_to_FU, Go_to_WU,
        output arrived, unit_lap_done, clear_fault,
        input  busy, task_done, tasks_completed, fault
    );

endinterface
`default_nettype wire

// File: rtl/mission_task_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mission_task_fifo
//  Purpose  : Small FIFO of 2-bit unit codes. A push is refused when full,
//             even if a pop happens in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module mission_task_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic       i_push,
    input  wire logic [1:0] i_data,
    input  wire logic       i_pop,
    output logic [1:0]      o_data,
    output logic            o_full,
    output logic            o_empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [1:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_push;
    logic        w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/mission_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : mission_scheduler
//  Purpose  : Queues PU/FU/WU delivery tasks, requests a path per task,
//             drives turn_direction_logic through path and unit legs and
//             retires tasks on unit_lap_done.
//  Options  : MISSION_WDOG_EN - per-leg watchdog of TIMEOUT_CYCLES cycles
//  Revision : 1.0 - initial release
// ============================================================================
module mission_scheduler
    import mission_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [4:0]  PU_ENTRY_NODE  = 5'd1,
    parameter logic [4:0]  FU_ENTRY_NODE  = 5'd11,
    parameter logic [4:0]  WU_ENTRY_NODE  = 5'd22,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    mission_scheduler_if.master  bus
);

    state_t      r_state;
    logic [1:0]  r_unit;
    logic        r_plan_req;
    logic [4:0]  r_plan_target;
    logic [23:0] r_node_dirs;
    logic [3:0]  r_path_len;
    logic [4:0]  r_prev_node;
    logic        r_nav_reset;
    logic [2:0]  r_go;
    logic        r_task_done;
    logic [7:0]  r_count;
    logic        r_arr_q;
    logic        r_lap_q;
    logic        r_entry;

    logic [1:0]  w_head;
    logic [4:0]  w_head_target;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_arr_rise;
    logic        w_lap_rise;
    logic        w_wdog_expire;

    assign w_pop      = (r_state == ST_IDLE) && !w_empty;
    assign w_arr_rise = bus.arrived & ~r_arr_q;
    assign w_lap_rise = bus.unit_lap_done & ~r_lap_q;

    mission_task_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (bus.task_valid),
        .i_data  (bus.task_unit),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Planner target node for the unit at the head of the queue
    always_comb begin
        w_head_target = 5'd0;
        case (w_head)
            UNIT_PU: w_head_target = PU_ENTRY_NODE;
            UNIT_FU: w_head_target = FU_ENTRY_NODE;
            UNIT_WU: w_head_target = WU_ENTRY_NODE;
            default: w_head_target = 5'd0;
        endcase
    end

`ifdef MISSION_WDOG_EN
    logic [31:0] r_wdog;
    logic [31:0] w_leg_count;

    // r_entry marks cycle 0 of every state, so the effective count restarts
    // on each leg entry without needing the next-state value here
    assign w_leg_count   = r_entry ? 32'd0 : r_wdog;
    assign w_wdog_expire = (w_leg_count == TIMEOUT_CYCLES - 32'd1);

    // Leg cycle counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_wdog <= 32'd0;
        else          r_wdog <= w_leg_count + 32'd1;
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_wdog_expire    = 1'b0;
`endif

    // Scheduler FSM with registered outputs and edge detectors
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_unit        <= 2'd0;
            r_plan_req    <= 1'b0;
            r_plan_target <= 5'd0;
            r_node_dirs   <= 24'd0;
            r_path_len    <= 4'd0;
            r_prev_node   <= 5'd0;
            r_nav_reset   <= 1'b0;
            r_go          <= 3'b000;
            r_task_done   <= 1'b0;
            r_count       <= 8'd0;
            r_arr_q       <= 1'b0;
            r_lap_q       <= 1'b0;
            r_entry       <= 1'b0;
        end else begin
            r_arr_q     <= bus.arrived;
            r_lap_q     <= bus.unit_lap_done;
            r_entry     <= 1'b0;
            r_nav_reset <= 1'b0;
            r_task_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Reserved unit codes are popped and silently dropped
                    if (!w_empty && (w_head != UNIT_RSVD)) begin
                        r_unit        <= w_head;
                        r_plan_target <= w_head_target;
                        r_plan_req    <= 1'b1;
                        r_state       <= ST_REQ_PATH;
                        r_entry       <= 1'b1;
                    end
                end
                ST_REQ_PATH: begin
                    if (bus.plan_ack) begin
                        r_node_dirs <= bus.plan_dirs;
                        r_path_len  <= bus.plan_len;
                        r_prev_node <= bus.plan_prev;
                        r_plan_req  <= 1'b0;
                        r_entry     <= 1'b1;
                        if (bus.plan_len > MAX_PATH_NODES) begin
                            r_state <= ST_FAULT;
                        end else if (bus.plan_len == 4'd0) begin
                            r_state     <= ST_RUN_UNIT;
                            r_go        <= unit_onehot(r_unit);
                            r_nav_reset <= 1'b1;
                        end else begin
                            r_state     <= ST_RUN_PATH;
                            r_nav_reset <= 1'b1;
                        end
                    end else if (w_wdog_expire) begin
                        r_plan_req <= 1'b0;
                        r_state    <= ST_FAULT;
                        r_entry    <= 1'b1;
                    end
                end
                ST_RUN_PATH: begin
                    // An edge on the entry cycle may be a stale level
                    if (w_arr_rise && !r_entry) begin
                        r_state     <= ST_RUN_UNIT;
                        r_go        <= unit_onehot(r_unit);
                        r_nav_reset <= 1'b1;
                        r_entry     <= 1'b1;
                    end else if (w_wdog_expire) begin
                        r_state <= ST_FAULT;
                        r_entry <= 1'b1;
                    end
                end
                ST_RUN_UNIT: begin
                    if (w_lap_rise && !r_entry) begin
                        r_state     <= ST_DONE;
                        r_go        <= 3'b000;
                        r_task_done <= 1'b1;
                        r_count     <= r_count + 8'd1;
                        r_entry     <= 1'b1;
                    end else if (w_wdog_expire) begin
                        r_state <= ST_FAULT;
                        r_go    <= 3'b000;
                        r_entry <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_entry <= 1'b1;
                end
                ST_FAULT: begin
                    r_go       <= 3'b000;
                    r_plan_req <= 1'b0;
                    if (bus.clear_fault) begin
                        r_state <= ST_IDLE;
                        r_entry <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.task_ready             = ~w_full;
    assign bus.plan_req               = r_plan_req;
    assign bus.plan_target            = r_plan_target;
    assign bus.node_directions        = r_node_dirs;
    assign bus.path_length            = r_path_len;
    assign bus.prev_node_of_end_point = r_prev_node;
    assign bus.nav_reset              = r_nav_reset;
    assign bus.Go_to_PU               = r_go[0];
    assign bus.Go_to_FU               = r_go[1];
    assign bus.Go_to_WU               = r_go[2];
    assign bus.busy                   = (r_state != ST_IDLE);
    assign bus.task_done              = r_task_done;
    assign bus.tasks_completed        = r_count;
    assign bus.fault                  = (r_state == ST_FAULT);

endmodule
`default_nettype wire
